// File: rtl/fetch_unit.sv
// Instruction fetch stage: one-at-a-time imem requests, 2-entry byte queue to
// decode, branch/jump redirect with discard of stale in-flight responses.
module fetch_unit #(
   parameter int unsigned         PC_W     = 8,
   parameter logic [PC_W-1:0]     RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rstN,
   output logic            imemReq,
   output logic [PC_W-1:0] imemAddr,
   input  logic            imemAck,
   input  logic [7:0]      imemData,
   output logic [7:0]      instOut,
   output logic [PC_W-1:0] pcOut,
   output logic            instValid,
   input  logic            instReady,
   input  logic            redirect,
   input  logic [PC_W-1:0] redirectPc
);

   localparam int unsigned DATA_W = 8;
   localparam int unsigned CNT_W  = 2;

   typedef enum logic [1:0] {S_RUN, S_WAIT, S_FLUSH} state_t;

   state_t              state_q, state_d;
   logic [PC_W-1:0]     fetch_pc_q, fetch_pc_d;
   logic [PC_W-1:0]     req_pc_q, req_pc_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic [PC_W-1:0]     head_pc_q, head_pc_d, tail_pc_q, tail_pc_d;
   logic [DATA_W-1:0]   head_data_q, head_data_d, tail_data_q, tail_data_d;
   logic                issue, push, pop, valid_c;

   // State register
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state_q     <= S_RUN;
         fetch_pc_q  <= RESET_PC;
         req_pc_q    <= RESET_PC;
         count_q     <= '0;
         head_pc_q   <= '0;
         head_data_q <= '0;
         tail_pc_q   <= '0;
         tail_data_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         req_pc_q    <= req_pc_d;
         count_q     <= count_d;
         head_pc_q   <= head_pc_d;
         head_data_q <= head_data_d;
         tail_pc_q   <= tail_pc_d;
         tail_data_q <= tail_data_d;
      end
   end

   // Next-state: fetch control and queue update
   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      req_pc_d    = req_pc_q;
      count_d     = count_q;
      head_pc_d   = head_pc_q;
      head_data_d = head_data_q;
      tail_pc_d   = tail_pc_q;
      tail_data_d = tail_data_q;
      issue       = 1'b0;
      push        = 1'b0;
      valid_c     = (count_q != '0) && !redirect;
      pop         = valid_c && instReady;

      case (state_q)
         S_RUN: begin
            if (redirect) begin
               fetch_pc_d = redirectPc;
            end else if (count_q < CNT_W'(2)) begin
               issue      = 1'b1;
               req_pc_d   = fetch_pc_q;
               fetch_pc_d = fetch_pc_q + PC_W'(1);
               state_d    = S_WAIT;
            end
         end
         S_WAIT: begin
            if (redirect) begin
               fetch_pc_d = redirectPc;
               state_d    = imemAck ? S_RUN : S_FLUSH;
            end else if (imemAck) begin
               push    = 1'b1;
               state_d = S_RUN;
            end
         end
         S_FLUSH: begin
            if (redirect) fetch_pc_d = redirectPc;
            if (imemAck) state_d = S_RUN;
         end
         default: state_d = S_RUN;
      endcase

      // Redirect empties the queue and wins over any push/pop
      if (redirect) begin
         count_d = '0;
      end else begin
         case ({push, pop})
            2'b10: begin
               if (count_q == '0) begin
                  head_pc_d   = req_pc_q;
                  head_data_d = imemData;
               end else begin
                  tail_pc_d   = req_pc_q;
                  tail_data_d = imemData;
               end
               count_d = count_q + CNT_W'(1);
            end
            2'b01: begin
               head_pc_d   = tail_pc_q;
               head_data_d = tail_data_q;
               count_d     = count_q - CNT_W'(1);
            end
            2'b11: begin
               if (count_q == CNT_W'(1)) begin
                  head_pc_d   = req_pc_q;
                  head_data_d = imemData;
               end else begin
                  head_pc_d   = tail_pc_q;
                  head_data_d = tail_data_q;
                  tail_pc_d   = req_pc_q;
                  tail_data_d = imemData;
               end
            end
            default: ;
         endcase
      end
   end

   // Request is masked while reset is asserted so it reads 0 during reset
   assign imemReq   = issue && rstN;
   assign imemAddr  = fetch_pc_q;
   assign instValid = valid_c;
   assign instOut   = head_data_q;
   assign pcOut     = head_pc_q;

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the instruction decoder. Holds the program counter, issues one-at-a-time read requests to instruction memory, and buffers returned 8-bit instruction bytes with their PCs in a 2-entry queue. Presents them to decode through a valid/ready handshake. Accepts branch/jump redirects from the execute stage and discards any stale in-flight fetch.

## Interface
- PC_W, 8, program counter / instruction address width
- RESET_PC, 0, fetch address after reset

- clk  in  1  rising-edge clock
- rstN  in  1  reset, asynchronous, active-low
- imemReq  out  1  read request, single-cycle pulse
- imemAddr  out  PC_W  read address, valid when imemReq=1
- imemAck  in  1  response strobe, one cycle, at least 1 cycle after request
- imemData  in  8  instruction byte, valid when imemAck=1
- instOut  out  8  head instruction, drives decoder instIn
- pcOut  out  PC_W  PC of instOut
- instValid  out  1  instOut/pcOut valid
- instReady  in  1  decode accepts head this cycle
- redirect  in  1  taken branch/jump, one-cycle strobe
- redirectPc  in  PC_W  new fetch address when redirect=1

## Operation
- States: RUN (no request outstanding), WAIT (one request outstanding, response kept), FLUSH (one request outstanding, response discarded).
- RUN: imemReq = (count<2) && !redirect; imemAddr = fetchPc. On issue: fetchPc <= fetchPc+1 (mod 2^PC_W, 255->0 at PC_W=8); go to WAIT.
- WAIT: imemAck && !redirect -> push {fetchPc-1 captured at issue, imemData} into queue; go to RUN.
- Redirect in RUN: fetchPc <= redirectPc; no request that cycle; stay RUN.
- Redirect in WAIT without ack: fetchPc <= redirectPc; go to FLUSH.
- Redirect in WAIT with ack: ack dropped, no push; fetchPc <= redirectPc; go to RUN.
- FLUSH: imemAck -> drop, go to RUN. A further redirect updates fetchPc and keeps FLUSH, or goes to RUN if imemAck is high in the same cycle.
- Queue: 2 entries, count 0..2. instValid = (count!=0) && !redirect. Pop when instValid && instReady. Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect clears the queue (count <= 0) on that edge, overriding any push or pop.
- Issue gating guarantees no overflow: at most one outstanding request, issued only with count<=1.
- imemAck in RUN is a protocol error and is ignored (no push).
- Reset (async, any time): state=RUN, fetchPc=RESET_PC, count=0, outstanding request forgotten. Reset values: imemReq=0, imemAddr=RESET_PC, instValid=0, instOut=0, pcOut=0. The first request is issued in the first cycle with rstN high.

## Timing
- Request-to-valid: req at cycle N, ack at N+k (k>=1), instValid high from N+k+1.
- Steady state with k=1 and instReady=1: one instruction per 2 cycles.
- Redirect at cycle N: instValid low in cycle N. With no request outstanding, the first request to redirectPc is issued at N+1.
- Redirect with a request outstanding: no new request until the stale ack arrives. The new request is issued the cycle after that ack.
- instOut/pcOut are stable while instValid && !instReady; the head changes only on pop or redirect.
- All outputs except instValid's redirect mask and imemReq's gating are registered.

## Test plan
- Reset: hold rstN=0 → imemReq=0, instValid=0, imemAddr=0. Release with RESET_PC=0, k=1, instReady=1, memory returns byte=addr → imemAddr sequence 0,1,2…; instOut/pcOut pairs (0,0),(1,1),(2,2), each valid 2 cycles after its request.
- Backpressure: instReady=0 → two entries queued (pc 0,1); imemReq stays 0 once count=2. Raise instReady → pcs 0,1,2 in order, no loss or duplicate.
- Redirect in WAIT with k=3: redirect to 0x40 one cycle after the request → stale ack dropped. The next imemAddr is 0x40 in the cycle after the stale ack; the next instValid carries pcOut=0x40.
- Simultaneous redirect and ack: redirect to 0x10 in the ack cycle → no push; request to 0x10 on the next cycle; queue empty meanwhile.
- Wrap: redirect to 0xFE → fetched PCs 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-WAIT: assert rstN=0 asynchronously between req and ack → outputs return to reset values immediately. A late ack arriving during reset is ignored; after release, the fetch restarts at RESET_PC.
